cpu_run_ctrl: RTL
=================

# cpu_run_ctrl

Run controller sitting between `projectCPU2021` and the shared `blram`, sequencing one complete program run. It streams a program image into RAM while holding the CPU in reset, releases the CPU, and detects halt (PC stuck on a self-jump). It then re-freezes the CPU and opens a read-back port so the bench or a host can dump memory. It owns the RAM port mux and CPU reset; the CPU and `blram` are unchanged.

## Interface
- `ADDR_W`, 13: RAM address width; matches CPU `addr_toRAM`.
- `DATA_W`, 16: RAM word width.
- `HALT_CYCLES`, 16: consecutive RUN cycles with unchanged `cpu_pc` that mean halt; legal range 2..255.
- `BUDGET_W`, 16: width of run cycle counter and budget.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a run from IDLE or DONE.
- `load_count` in ADDR_W: number of words to load; sampled on accepted `start`.
- `load_valid` / `load_ready` in/out 1: program stream handshake.
- `load_data` in DATA_W: program word; word k is written to address k.
- `cpu_rst` out 1: active-high reset to CPU.
- `cpu_pc` in ADDR_W: CPU PC.
- `cpu_we`, `cpu_addr`, `cpu_wdata` in 1/ADDR_W/DATA_W: CPU RAM request.
- `ram_we`, `ram_addr`, `ram_wdata` out 1/ADDR_W/DATA_W: to `blram`.
- `ram_rdata` in DATA_W: from `blram`. Read data is valid the cycle after the address.
- `rd_req`, `rd_addr` in 1/ADDR_W: read-back request; honoured in DONE only.
- `rd_valid`, `rd_data` out 1/DATA_W: read-back response.
- `busy` out 1: high outside IDLE and DONE.
- `done`, `timeout` out 1: run status. Sticky until next accepted `start`.
- `run_cycles` out BUDGET_W: RUN cycles of the last run.
- `budget` in BUDGET_W: watchdog limit (present only with the macro).

## Operation
- States: IDLE, LOAD, RELEASE, RUN, DONE.
- Reset (`rst`=0 at an edge): state IDLE, `cpu_rst`=1, `ram_we`=0, `load_ready`=0, `rd_valid`=0, `busy`=0, `done`=0, `timeout`=0, `run_cycles`=0, load pointer 0.
- IDLE/DONE + `start`:
  - Clear `done`, `timeout` and `run_cycles`; latch `load_count`.
  - Go to LOAD, or to RELEASE if `load_count`=0.
  - `start` in any other state is ignored.
- LOAD:
  - `load_ready`=1 and `cpu_rst`=1.
  - Each accepted handshake drives `ram_we`=1, `ram_addr`=pointer, `ram_wdata`=`load_data` combinationally, then increments the pointer.
  - After word `load_count`-1 is accepted, go to RELEASE.
  - Gaps in `load_valid` stall with no write.
- RELEASE: one cycle; `cpu_rst`=1, RAM idle; next state RUN.
- RUN:
  - `cpu_rst`=0; RAM port is a pass-through of `cpu_we`, `cpu_addr` and `cpu_wdata`.
  - `run_cycles` increments each cycle and saturates at all-ones.
  - Halt detector: counter resets to 1 whenever `cpu_pc` differs from the registered previous PC, otherwise increments.
  - Reaching `HALT_CYCLES` sets `done`, and the next state is DONE.
- DONE:
  - `cpu_rst`=1, `ram_we`=0.
  - `rd_req` drives `ram_addr`=`rd_addr`. Exactly one cycle later `rd_valid`=1 and `rd_data`=`ram_rdata`.
  - Back-to-back requests give one response per cycle.
  - `rd_req` outside DONE is dropped and produces no `rd_valid`.
- Simultaneous events:
  - `start` with `rd_req` in DONE: read is served, and the response still appears next cycle while in LOAD.
  - Halt and watchdog in the same cycle: `done`=1 and `timeout`=1.

## Timing
- Load throughput: 1 word/cycle.
- `start` to first `load_ready`: 1 cycle.
- After the last load word: 1 cycle in RELEASE, then `cpu_rst` falls.
- Halt is declared `HALT_CYCLES`-1 cycles after the PC last changed. `done` rises on the following edge.
- Read-back latency: 1 cycle.
- `rst` mid-run aborts the run immediately and returns to IDLE. An in-flight load word is lost.

## Configuration
- `CPU_RUN_CTRL_WATCHDOG_EN` defined:
  - `budget` port exists.
  - In RUN, when `run_cycles` reaches `budget` (and `budget` is not 0), set `timeout`=1 and `done`=1 and go to DONE.
- Undefined: no `budget` port, `timeout` is tied 0, and RUN ends only on halt.

## Structure
- `cpu_run_ctrl_pkg`: state enum, default widths, RAM mux select encoding (LOADER/CPU/READBACK).
- Sub-module `pc_halt_detector`: previous-PC register and stable counter with inputs `clk`, `rst`, `en`, `pc` and output `halted`. It is cleared when not enabled.

## Test plan
- Reset held 3 cycles mid-LOAD:
  - `cpu_rst`=1, state IDLE, `load_ready`=0, `busy`=0.
  - Next `start` reloads from address 0.
- `load_count`=4, words 16'h1111..16'h4444 with a 2-cycle `load_valid` gap:
  - RAM[0..3] hold the words, and exactly 4 writes occur.
  - `cpu_rst` falls 2 cycles after the last handshake.
- Program ending in a self-jump at PC 158:
  - `done`=1 within `HALT_CYCLES`+1 cycles of PC settling at 158.
  - `cpu_rst`=1 afterwards; `run_cycles` is nonzero and stable.
- DONE, `rd_req` at addresses 72 then 147 on consecutive cycles (RAM 255, 16'hDEAF):
  - `rd_valid` on two consecutive cycles with `rd_data` 255 then 16'hDEAF.
- `start` during RUN, and `rd_req` during RUN: both ignored; no `rd_valid`; run completes normally.
- Watchdog build, `budget`=50, program looping over two PCs:
  - `timeout`=1 and `done`=1 with `run_cycles`=50.
- Non-watchdog build, same program: still in RUN at cycle 1000.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the CPU run controller: FSM state encoding, RAM port mux select, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_run_ctrl_pkg;

    localparam int ADDR_W_DEF      = 13;
    localparam int DATA_W_DEF      = 16;
    localparam int HALT_CYCLES_DEF = 16;
    localparam int BUDGET_W_DEF    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RELEASE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Who owns the shared RAM port this cycle.
    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_LOADER,
        SEL_CPU,
        SEL_READBACK
    } ram_sel_t;

    // IDLE and DONE are the only states where a new run may be started.
    function automatic logic is_quiet(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/pc_halt_detector.sv
// Halt detector: flags a CPU halt once the PC has held one value for HALT_CYCLES consecutive enabled cycles.
// Latency: combinational flag in the cycle the stable count reaches HALT_CYCLES.
// Backpressure: none; state is cleared whenever en is low.
// Ports: clk, rst (sync active-low), en (count enable), pc (current CPU PC), halted (halt flag).
module pc_halt_detector #(
    parameter int PC_W        = 13,
    parameter int HALT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [PC_W-1:0] pc,
    output logic            halted
);

    // HALT_CYCLES is at most 255, so 8 bits hold any meaningful count.
    localparam int CNT_W = 8;

    logic [PC_W-1:0]  prev_pc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // cnt == 0 marks "no previous PC yet": the first enabled cycle always counts as 1.
    always_comb begin
        cnt_next = cnt;
        if ((cnt == '0) || (pc != prev_pc)) begin
            cnt_next = CNT_W'(1);
        end else if (cnt != '1) begin
            cnt_next = cnt + 1'b1;
        end
    end

    assign halted = en && (cnt_next == CNT_W'(HALT_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            prev_pc <= '0;
            cnt     <= '0;
        end else begin
            prev_pc <= pc;
            cnt     <= cnt_next;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: loads a program image into RAM with the CPU in reset, runs the CPU until halt, then serves RAM read-back.
// Latency: start->load_ready 1 cycle; last load word->cpu_rst low 2 cycles; read-back 1 cycle.
// Backpressure: load stream stalls on load_valid gaps; load_ready only in LOAD; rd_req honoured in DONE only.
// Ports: clk/rst (sync active-low); start/load_count; load_valid/load_ready/load_data stream; cpu_rst, cpu_pc and
// CPU RAM request (cpu_we/addr/wdata); RAM port (ram_we/addr/wdata/rdata); rd_req/rd_addr -> rd_valid/rd_data;
// status busy/done/timeout/run_cycles. Optional macro CPU_RUN_CTRL_WATCHDOG_EN adds the budget input and watchdog.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int HALT_CYCLES = HALT_CYCLES_DEF,
    parameter int BUDGET_W    = BUDGET_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   load_count,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [DATA_W-1:0]   load_data,
    output logic                cpu_rst,
    input  logic [ADDR_W-1:0]   cpu_pc,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [BUDGET_W-1:0] run_cycles
`ifdef CPU_RUN_CTRL_WATCHDOG_EN
    ,
    input  logic [BUDGET_W-1:0] budget
`endif
);

    state_t              state;
    state_t              state_next;
    ram_sel_t            sel;
    logic [ADDR_W-1:0]   load_len;
    logic [ADDR_W-1:0]   ptr;
    logic [BUDGET_W-1:0] run_cycles_inc;
    logic                halt_en;
    logic                halted;
    logic                wd_hit;
    logic                start_acc;
    logic                run_end;

    assign start_acc      = is_quiet(state) && start;
    assign run_cycles_inc = (run_cycles == '1) ? run_cycles : run_cycles + 1'b1;
    assign run_end        = halted || wd_hit;

    pc_halt_detector #(
        .PC_W        (ADDR_W),
        .HALT_CYCLES (HALT_CYCLES)
    ) u_halt (
        .clk    (clk),
        .rst    (rst),
        .en     (halt_en),
        .pc     (cpu_pc),
        .halted (halted)
    );

`ifdef CPU_RUN_CTRL_WATCHDOG_EN
    logic timeout_q;

    // Compare against the post-increment count so run_cycles equals budget when the run stops.
    assign wd_hit  = (state == ST_RUN) && (budget != '0) && (run_cycles_inc == budget);
    assign timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            timeout_q <= 1'b0;
        end else if (start_acc) begin
            timeout_q <= 1'b0;
        end else if (wd_hit) begin
            timeout_q <= 1'b1;
        end
    end
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sel        = SEL_NONE;
        load_ready = 1'b0;
        cpu_rst    = 1'b1;
        busy       = 1'b1;
        halt_en    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                busy = 1'b0;
                if (state == ST_DONE) begin
                    sel = SEL_READBACK;
                end
                if (start) begin
                    state_next = (load_count == '0) ? ST_RELEASE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_ready = 1'b1;
                sel        = SEL_LOADER;
                if (load_valid && (ptr == load_len - 1'b1)) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                cpu_rst = 1'b0;
                sel     = SEL_CPU;
                halt_en = 1'b1;
                if (run_end) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Shared RAM port mux; RELEASE and IDLE leave the port idle.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (sel)
            SEL_LOADER: begin
                ram_we    = load_valid;
                ram_addr  = ptr;
                ram_wdata = load_data;
            end
            SEL_CPU: begin
                ram_we    = cpu_we;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
            end
            SEL_READBACK: begin
                ram_addr = rd_addr;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    // RAM read data arrives the cycle after the address, so the response is simply flagged one cycle later;
    // it still appears if start moved the FSM on to LOAD in the meantime.
    assign rd_data = rd_valid ? ram_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr        <= '0;
            load_len   <= '0;
            done       <= 1'b0;
            run_cycles <= '0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= (state == ST_DONE) && rd_req;
            if (start_acc) begin
                done       <= 1'b0;
                run_cycles <= '0;
                load_len   <= load_count;
                ptr        <= '0;
            end else if (state == ST_LOAD) begin
                if (load_valid) begin
                    ptr <= ptr + 1'b1;
                end
            end else if (state == ST_RUN) begin
                run_cycles <= run_cycles_inc;
                if (run_end) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
